// File: rtl/systolic_pkg.sv
// Shared FSM type, default widths and the output conversion helper for the systolic tile.
// SYSTOLIC_OS_TILE_SATURATE_EN switches sat_trunc from truncation to signed clamping.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN
    } tile_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ROWS       = 8;
    localparam int DEF_COLS       = 8;
    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_OUT_WIDTH  = 16;
    localparam int DEF_K_MAX      = 256;

    // Caller keeps the low ow bits of the result; acc arrives sign-extended to 64 bits.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] acc, input int ow);
`ifdef SYSTOLIC_OS_TILE_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (acc > hi) return hi;
        if (acc < lo) return lo;
        return acc;
`else
        return acc & ((64'sd1 <<< ow) - 64'sd1);
`endif
    endfunction

endpackage

// File: rtl/pe_os_cell.sv
// Output-stationary PE: registered a/b pass-through and a wrapping signed MAC accumulator.
module pe_os_cell
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         adv,
    input  logic                         clr,
    input  logic signed [DATA_WIDTH-1:0] a_in,
    input  logic signed [DATA_WIDTH-1:0] b_in,
    output logic signed [DATA_WIDTH-1:0] a_out,
    output logic signed [DATA_WIDTH-1:0] b_out,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] prod;

    // Product of the currently held operands, folded in before they move on.
    assign prod = a_out * b_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            if (adv) begin
                a_out <= a_in;
                b_out <= b_in;
            end
            if (clr) begin
                acc <= '0;
            end else if (adv) begin
                acc <= acc + ACC_WIDTH'(prod);
            end
        end
    end

endmodule

// File: rtl/systolic_os_tile.sv
// Output-stationary systolic matmul tile: skewed operand feed, zero flush, row-wise drain.
// Output conversion honours SYSTOLIC_OS_TILE_SATURATE_EN (see systolic_pkg::sat_trunc).
//   state    | meaning
//   ST_IDLE  | waiting for start; k_len==0 only pulses done
//   ST_FEED  | accepting k_len operand beats, array advances per beat
//   ST_FLUSH | injecting zeros for ROWS+COLS-1 cycles to finish all products
//   ST_DRAIN | presenting accumulator rows 0..ROWS-1 under out_valid/out_ready
module systolic_os_tile
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int K_MAX      = DEF_K_MAX
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(K_MAX+1)-1:0]    k_len,
    input  logic                          acc_en,
    output logic                          busy,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]    a_col,
    input  logic [COLS*DATA_WIDTH-1:0]    b_row,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COLS*OUT_WIDTH-1:0]     out_row,
    output logic [$clog2(ROWS)-1:0]       out_row_idx,
    output logic                          done
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int IW = $clog2(ROWS);
    localparam int FW = $clog2(ROWS + COLS);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);
    localparam logic [IW-1:0] ROW_LAST   = IW'(ROWS - 1);

    tile_state_t   state_q, state_d;
    logic [KW-1:0] beat_cnt_q, beat_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic [IW-1:0] row_idx_q, row_idx_d;
    logic          done_q, done_d;
    logic          adv;
    logic          clr;

    logic signed [DATA_WIDTH-1:0] a_edge [ROWS];
    logic signed [DATA_WIDTH-1:0] b_edge [COLS];
    logic signed [DATA_WIDTH-1:0] a_pass [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] b_pass [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]  acc_arr [ROWS][COLS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            row_idx_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            row_idx_q   <= row_idx_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        row_idx_d   = row_idx_q;
        done_d      = 1'b0;
        clr         = 1'b0;
        adv         = 1'b0;
        busy        = (state_q != ST_IDLE);
        in_ready    = (state_q == ST_FEED);
        out_valid   = (state_q == ST_DRAIN);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (k_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_FEED;
                        beat_cnt_d = k_len;
                        clr        = !acc_en;
                    end
                end
            end
            ST_FEED: begin
                if (in_valid) begin
                    adv        = 1'b1;
                    beat_cnt_d = beat_cnt_q - KW'(1);
                    if (beat_cnt_q == KW'(1)) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LAST;
                    end
                end
            end
            ST_FLUSH: begin
                adv = 1'b1;
                if (flush_cnt_q == '0) begin
                    state_d   = ST_DRAIN;
                    row_idx_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FW'(1);
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (row_idx_q == ROW_LAST) begin
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                        row_idx_d = '0;
                    end else begin
                        row_idx_d = row_idx_q + IW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign done        = done_q;
    assign out_row_idx = row_idx_q;

    // Row i of A is delayed i advances so element k meets B's element k at PE(i,j).
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        logic signed [DATA_WIDTH-1:0] a_feed;
        assign a_feed = (state_q == ST_FEED) ? a_col[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (i == 0) begin : g_direct
            assign a_edge[i] = a_feed;
        end else begin : g_line
            logic signed [DATA_WIDTH-1:0] line [i];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < i; s++) line[s] <= '0;
                end else if (adv) begin
                    line[0] <= a_feed;
                    for (int s = 1; s < i; s++) line[s] <= line[s-1];
                end
            end
            assign a_edge[i] = line[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        logic signed [DATA_WIDTH-1:0] b_feed;
        assign b_feed = (state_q == ST_FEED) ? b_row[j*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (j == 0) begin : g_direct
            assign b_edge[j] = b_feed;
        end else begin : g_line
            logic signed [DATA_WIDTH-1:0] line [j];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < j; s++) line[s] <= '0;
                end else if (adv) begin
                    line[0] <= b_feed;
                    for (int s = 1; s < j; s++) line[s] <= line[s-1];
                end
            end
            assign b_edge[j] = line[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic signed [DATA_WIDTH-1:0] a_src;
            logic signed [DATA_WIDTH-1:0] b_src;
            if (j == 0) begin : g_a_edge
                assign a_src = a_edge[i];
            end else begin : g_a_link
                assign a_src = a_pass[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_src = b_edge[j];
            end else begin : g_b_link
                assign b_src = b_pass[i-1][j];
            end
            pe_os_cell #(
                .DATA_WIDTH(DATA_WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .clk  (clk),
                .rst  (rst),
                .adv  (adv),
                .clr  (clr),
                .a_in (a_src),
                .b_in (b_src),
                .a_out(a_pass[i][j]),
                .b_out(b_pass[i][j]),
                .acc  (acc_arr[i][j])
            );
        end
    end

    always_comb begin
        out_row = '0;
        if (state_q == ST_DRAIN) begin
            for (int j = 0; j < COLS; j++) begin
                out_row[j*OUT_WIDTH +: OUT_WIDTH] =
                    OUT_WIDTH'(sat_trunc(64'(acc_arr[row_idx_q][j]), OUT_WIDTH));
            end
        end
    end

endmodule

// File: tb/tb_systolic_os_tile.sv
// Bench for systolic_os_tile: randomized operand runs checked against a matrix-level model.
module tb_systolic_os_tile;

    localparam int DW = 8, R = 8, C = 8, AW = 32, OW = 16, KM = 256;
    localparam int KW = $clog2(KM + 1), IW = $clog2(R);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [KW-1:0]     k_len = '0;
    logic              acc_en = 1'b0;
    logic              busy;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [R*DW-1:0]   a_col = '0;
    logic [C*DW-1:0]   b_row = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [C*OW-1:0]   out_row;
    logic [IW-1:0]     out_row_idx;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    logic signed [DW-1:0] a_mem [KM][R];
    logic signed [DW-1:0] b_mem [KM][C];
    int                   m_acc [R][C];

    systolic_os_tile #(
        .DATA_WIDTH(DW), .ROWS(R), .COLS(C), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .K_MAX(KM)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_en(acc_en), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // C = A*B over k beats; int arithmetic wraps exactly like a 32-bit accumulator.
    task automatic model_apply(input int k, input bit ae);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                if (!ae) m_acc[i][j] = 0;
                for (int kk = 0; kk < k; kk++)
                    m_acc[i][j] += int'(a_mem[kk][i]) * int'(b_mem[kk][j]);
            end
    endtask

    function automatic logic [OW-1:0] exp_elem(input int v);
`ifdef SYSTOLIC_OS_TILE_SATURATE_EN
        if (v > 32767) return 16'h7fff;
        if (v < -32768) return 16'h8000;
`endif
        return v[OW-1:0];
    endfunction

    function automatic logic [C*OW-1:0] exp_row(input int r);
        logic [C*OW-1:0] v;
        v = '0;
        for (int j = 0; j < C; j++) v[j*OW +: OW] = exp_elem(m_acc[r][j]);
        return v;
    endfunction

    task automatic fill_const(input int k, input int av, input int bv);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < R; i++) a_mem[kk][i] = DW'(av);
            for (int j = 0; j < C; j++) b_mem[kk][j] = DW'(bv);
        end
    endtask

    task automatic fill_idx(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < R; i++) a_mem[kk][i] = DW'(i);
            for (int j = 0; j < C; j++) b_mem[kk][j] = DW'(j);
        end
    endtask

    task automatic fill_rand(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < R; i++) a_mem[kk][i] = DW'($urandom);
            for (int j = 0; j < C; j++) b_mem[kk][j] = DW'($urandom);
        end
    endtask

    task automatic drive_beat(input int b);
        for (int i = 0; i < R; i++) a_col[i*DW +: DW] = a_mem[b][i];
        for (int j = 0; j < C; j++) b_row[j*DW +: DW] = b_mem[b][j];
    endtask

    // vmode: 0 gap-free, 1 alternate gaps, 2 random; rmode: 0 always ready, 1 stall row 3 x5, 2 random
    task automatic run_op(input int k, input bit ae, input int vmode, input int rmode, input bit chk_lat);
        int  cyc, beat, row, rdy_cyc, stall_left;
        bit  got_done;
        model_apply(k, ae);
        beat = 0; row = 0; rdy_cyc = 0; stall_left = 5; got_done = 1'b0;
        start = 1'b1; k_len = KW'(k); acc_en = ae; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        while (cyc < 4000) begin
            if (done) begin
                got_done = 1'b1;
                n_checks++;
                if (row !== R) begin n_errors++; $display("FAIL rows_before_done: got %0d rows, expected %0d", row, R); end
                if (chk_lat) begin
                    n_checks++;
                    if (cyc !== k + R + C - 1 + R + 1) begin
                        n_errors++; $display("FAIL latency: got %0d cycles, expected %0d", cyc, k + R + C - 1 + R + 1);
                    end
                    n_checks++;
                    if (rdy_cyc !== k) begin n_errors++; $display("FAIL in_ready_cycles: got %0d, expected %0d", rdy_cyc, k); end
                end
                break;
            end
            n_checks++;
            if (busy !== 1'b1) begin n_errors++; $display("FAIL busy_run: got %b at cycle %0d, expected 1", busy, cyc); end
            if (in_ready) rdy_cyc++;
            if (out_valid) begin
                n_checks++;
                if (row >= R) begin
                    n_errors++; $display("FAIL extra_row: out_valid with idx %0d after %0d rows", out_row_idx, row);
                end else if (out_row_idx !== IW'(row) || out_row !== exp_row(row)) begin
                    n_errors++;
                    $display("FAIL row: got idx %0d data %h, expected idx %0d data %h", out_row_idx, out_row, row, exp_row(row));
                end
            end
            if (beat < k) begin
                case (vmode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = cyc[0];
                    default: in_valid = 1'($urandom_range(0, 1));
                endcase
                drive_beat(beat);
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                a_col = {$urandom(), $urandom()};
                b_row = {$urandom(), $urandom()};
            end
            start  = ($urandom_range(0, 3) == 0);
            k_len  = KW'($urandom_range(0, 20));
            acc_en = 1'($urandom_range(0, 1));
            case (rmode)
                0: out_ready = 1'b1;
                1: if (row == 3 && stall_left > 0 && out_valid) begin out_ready = 1'b0; stall_left--; end
                   else out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (in_valid && in_ready && beat < k) beat++;
            if (out_valid && out_ready) row++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if (!got_done) begin
            n_checks++; n_errors++;
            $display("FAIL timeout: done not seen within %0d cycles (rows %0d)", cyc, row);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL done_pulse: got done %b busy %b after done, expected 0 0", done, busy);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if ({busy, in_ready, out_valid, done} !== 4'b0000) begin
            n_errors++; $display("FAIL %s_ctrl: got busy/in_ready/out_valid/done %b, expected 0000", tag, {busy, in_ready, out_valid, done});
        end
        n_checks++;
        if (out_row !== '0 || out_row_idx !== '0) begin
            n_errors++; $display("FAIL %s_data: got row %h idx %0d, expected 0 0", tag, out_row, out_row_idx);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_held");
        rst = 1'b0;
        for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) m_acc[i][j] = 0;
        @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_single_beat;
        fill_const(1, 1, 2);
        run_op(1, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_gaps_and_accumulate;
        fill_idx(3);
        run_op(3, 1'b0, 1, 0, 1'b0);
        run_op(3, 1'b0, 0, 0, 1'b1);
        n_checks++;
        if (m_acc[7][7] !== 147) begin n_errors++; $display("FAIL model_c77: got %0d, expected 147", m_acc[7][7]); end
        run_op(3, 1'b1, 1, 0, 1'b0);
        fill_const(1, 0, 0);
        run_op(1, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_backpressure;
        fill_rand(5);
        run_op(5, 1'b0, 0, 1, 1'b0);
    endtask

    task automatic test_overflow;
        fill_const(4, 127, 127);
        run_op(4, 1'b0, 0, 0, 1'b1);
        fill_const(4, -128, 127);
        run_op(4, 1'b0, 2, 0, 1'b0);
    endtask

    task automatic test_kzero;
        fill_rand(6);
        run_op(6, 1'b0, 0, 0, 1'b0);
        start = 1'b1; k_len = '0; acc_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_errors++; $display("FAIL kzero_done: got done %b busy %b in_ready %b, expected 1 0 0", done, busy, in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL kzero_pulse: got done %b busy %b, expected 0 0", done, busy);
        end
        fill_const(1, 0, 0);
        run_op(1, 1'b1, 0, 0, 1'b1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 6; n++) begin
            int k;
            k = $urandom_range(1, 20);
            fill_rand(k);
            run_op(k, 1'($urandom_range(0, 1)), 2, 2, 1'b0);
        end
    endtask

    task automatic test_rst_abort;
        fill_rand(5);
        start = 1'b1; k_len = KW'(5); acc_en = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; drive_beat(0);
        @(negedge clk);
        drive_beat(1);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL abort_pre: got busy %b in_ready %b, expected 1 1", busy, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL abort_async: got busy %b in_ready %b out_valid %b, expected 0 0 0", busy, in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) m_acc[i][j] = 0;
        @(negedge clk);
        start = 1'b1; k_len = '0; acc_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_errors++; $display("FAIL abort_kzero: got done %b busy %b, expected 1 0", done, busy);
        end
        @(negedge clk);
        fill_const(1, 1, 1);
        run_op(1, 1'b1, 0, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_gaps_and_accumulate();
        test_backpressure();
        test_overflow();
        test_kzero();
        test_random();
        test_rst_abort();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/systolic_os_tile.md
Name: systolic_os_tile

Overview:
Parametrised output-stationary systolic matrix-multiply tile. It computes C = A·B over a runtime K depth and accumulates on-tile. Internal input skew is built in, so upstream streams aligned A columns and B rows under a valid/ready handshake. Results are drained row by row under a second handshake, with optional accumulation across successive tiles.

Parameters:
DATA_WIDTH, 8, signed operand width
ROWS, 8, PE rows (A elements per beat)
COLS, 8, PE columns (B elements per beat)
ACC_WIDTH, 32, per-PE signed accumulator width
OUT_WIDTH, 16, per-element output width (OUT_WIDTH <= ACC_WIDTH)
K_MAX, 256, maximum K depth; KW = $clog2(K_MAX+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  start pulse, sampled in IDLE only
k_len  in  KW  K depth, sampled with start
acc_en  in  1  sampled with start; 1 = keep accumulators, 0 = clear them
busy  out  1  high in any state other than IDLE
in_valid  in  1  operand beat valid
in_ready  out  1  high only in FEED
a_col  in  ROWS*DATA_WIDTH  A column k; element i at bits [i*DW +: DW]
b_row  in  COLS*DATA_WIDTH  B row k; element j at bits [j*DW +: DW]
out_valid  out  1  result row valid
out_ready  in  1  result row accepted
out_row  out  COLS*OUT_WIDTH  C row out_row_idx; element j at bits [j*OW +: OW]
out_row_idx  out  $clog2(ROWS)  index of the row presented
done  out  1  one-cycle pulse at completion

Behaviour:
- Clock and reset:
  - Single clock clk.
  - Reset rst is asynchronous and active-high.
  - On rst: FSM = IDLE; all skew registers, PE pipeline registers, accumulators and counters = 0.
  - Reset values of outputs: busy, in_ready, out_valid, done = 0; out_row = 0; out_row_idx = 0.
- FSM states: IDLE, FEED, FLUSH, DRAIN.
- IDLE:
  - start && k_len>=1 -> FEED. Accumulators are cleared on the same edge iff acc_en==0.
  - start && k_len==0 -> done pulses the next cycle; FSM stays IDLE; accumulators are untouched.
- FEED:
  - in_ready=1. Each in_valid&&in_ready cycle is one beat and one array advance.
  - a_col[i] enters a skew line of depth i; b_row[j] enters a skew line of depth j.
  - Cycles without a beat freeze the whole array: skew registers, PE regs and accumulators hold.
  - After beat k_len -> FLUSH; in_ready drops in the cycle after the last beat.
- FLUSH:
  - Advances every cycle, injecting zeros, for exactly ROWS+COLS-1 cycles, then -> DRAIN.
  - start and in_valid are ignored.
- PE(i,j) on each advance: acc += sext(a_reg)*sext(b_reg). Then a passes right and b passes down.
- Product width is 2*DATA_WIDTH, sign-extended to ACC_WIDTH; accumulation wraps modulo 2^ACC_WIDTH.
- DRAIN:
  - out_valid=1; out_row_idx runs 0..ROWS-1 and advances on out_valid&&out_ready.
  - out_row and out_row_idx stay stable while out_valid && !out_ready.
  - After row ROWS-1 is accepted: out_valid=0, done=1 for one cycle, -> IDLE.
- Output conversion without the optional feature: out element = acc[OUT_WIDTH-1:0] (truncation).
- Accumulators persist after DRAIN; a later start with acc_en=1 adds onto them.
- start while busy: ignored.
- rst mid-operation: aborts at once (asynchronous); partial results are discarded, including accumulators.
- Latency: with no in_valid gaps and out_ready tied high, done is seen k_len + (ROWS+COLS-1) + ROWS + 1 cycles after the start cycle.

Optional Feature:
- Macro: SYSTOLIC_OS_TILE_SATURATE_EN.
- Defined: each output element is clamped to the signed OUT_WIDTH range [-2^(OW-1), 2^(OW-1)-1] before driving out_row.
- Undefined: plain truncation to the low OUT_WIDTH bits.
- Accumulators are never saturated in either case.

Decomposition:
- Shared package systolic_pkg holds:
  - FSM state enum (IDLE/FEED/FLUSH/DRAIN);
  - default width constants;
  - function sat_trunc(acc, OW) used by the output stage.
- One sub-module, pe_os_cell:
  - registered a/b pass-through, MAC accumulator, and clear/advance enables;
  - instantiated ROWS*COLS times.
- Skew lines and FSM stay in the top module.

Test Plan:
- k_len=1, acc_en=0, all a=1, all b=2, out_ready=1 -> rows 0..7 each all 2; done after 1+15+8+1 cycles; in_ready high for exactly 1 cycle.
- k_len=3, a_col[i]=i, b_row[j]=j every beat, in_valid low on alternate cycles -> C[i][j]=3*i*j (e.g. C[7][7]=147); identical to the gap-free run.
- Repeat the previous run with acc_en=1 -> C[i][j]=6*i*j; then run with acc_en=0, k_len=1, a=b=0 -> all zeros.
- out_ready low for 5 cycles while out_row_idx=3 -> out_row and idx stay stable; row 3 is delivered exactly once; done follows row 7.
- a=127, b=127, k_len=4 (acc=64516): with SATURATE_EN every element = 32767; without it every element = 16'hFC04; a=-128, b=127 with SATURATE_EN -> -32768.
- rst pulse mid-FEED -> busy, in_ready and out_valid are 0 immediately. A following start with k_len=0 gives a done pulse only. Then acc_en=1, k_len=1, a=b=1 gives all ones, proving the accumulators were cleared.
